// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART blocks (uart_tx_fifo, uart_rx).
//   tx_state_t          transmitter FSM states; PARITY is always present so the
//                       encoding is the same whether or not parity is built in
//   DEFAULT_BAUD_COUNT  clk cycles per bit (115200 baud at 74.25 MHz)
//   UART_DATA_BITS      data bits per frame
//   UART_IDLE_LEVEL     line level when nothing is being sent
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam int unsigned DEFAULT_BAUD_COUNT = 645;
  localparam int unsigned UART_DATA_BITS     = 8;
  localparam logic        UART_IDLE_LEVEL    = 1'b1;

  // Even parity bit: XOR of all data bits.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty flags and occupancy.
//   i_clk, i_rst_n   clock, asynchronous active-low reset (clears pointers only)
//   i_wr_en/i_wr_data  push; ignored while full, even if a pop happens that cycle
//   i_rd_en          pop head; ignored while empty
//   o_rd_data_c      current head entry (combinational read)
//   o_full, o_empty  registered status
//   o_count          registered occupancy, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data_c,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_empty;

  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_wr_ptr_next;
  logic [AW:0]      w_rd_ptr_next;
  logic [CW-1:0]    w_count_next;

  assign w_push = i_wr_en && !r_full;
  assign w_pop  = i_rd_en && !r_empty;

  // Pointers carry an extra wrap bit so equal low bits can mean full or empty.
  always_comb begin : ptr_next
    w_wr_ptr_next = r_wr_ptr;
    w_rd_ptr_next = r_rd_ptr;
    w_count_next  = r_count;
    if (w_push) w_wr_ptr_next = r_wr_ptr + (AW+1)'(1);
    if (w_pop)  w_rd_ptr_next = r_rd_ptr + (AW+1)'(1);
    w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  end

  // Status and pointer registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      r_full   <= (w_wr_ptr_next[AW] != w_rd_ptr_next[AW]) &&
                  (w_wr_ptr_next[AW-1:0] == w_rd_ptr_next[AW-1:0]);
      r_empty  <= (w_wr_ptr_next == w_rd_ptr_next);
    end
  end

  // Storage has no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data_c = r_mem[r_rd_ptr[AW-1:0]];
  assign o_full      = r_full;
  assign o_empty     = r_empty;
  assign o_count     = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1/8N2 UART transmitter with CTS flow control.
//   clk_in     clock
//   rst_in_n   asynchronous active-low reset (line goes idle, FIFO emptied)
//   data_in    byte to send, accepted when valid_in && ready_out at a rising edge
//   valid_in   data_in valid
//   ready_out  FIFO not full
//   cts_n_in   clear-to-send, active low, asynchronous; checked only at frame start
//   tx_out     serial line, idle high
//   busy_out   a frame is on the line or bytes are waiting
//   count_out  FIFO occupancy
// Build option: define UART_TX_PARITY_EN to add an even-parity bit after the data.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_COUNT = DEFAULT_BAUD_COUNT,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                          clk_in,
  input  logic                          rst_in_n,
  input  logic [UART_DATA_BITS-1:0]     data_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  input  logic                          cts_n_in,
  output logic                          tx_out,
  output logic                          busy_out,
  output logic [$clog2(FIFO_DEPTH):0]   count_out
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW = $clog2(BAUD_COUNT);
  localparam logic [2:0]  BIT_LAST  = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);

  logic                      r_cts_meta;
  logic                      r_cts_sync;
  logic                      w_cts_ok;

  logic                      w_full;
  logic                      w_empty;
  logic [UART_DATA_BITS-1:0] w_head;
  logic [CW-1:0]             w_count;
  logic                      w_pop;
  logic                      w_start_ok;

  tx_state_t                 r_state;
  tx_state_t                 w_state_next;
  logic [BW-1:0]             r_baud;
  logic [BW-1:0]             w_baud_next;
  logic [BW-1:0]             w_baud_inc;
  logic                      w_bit_end;
  logic [2:0]                r_bit;
  logic [2:0]                w_bit_next;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] w_shift_next;
  logic                      r_tx;
  logic                      w_tx_next;
  logic                      r_busy;
`ifdef UART_TX_PARITY_EN
  logic                      r_parity;
  logic                      w_parity_next;
`endif

  // Two-flop synchroniser; reset to "not clear" so nothing starts before it settles.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_cts_meta <= 1'b1;
      r_cts_sync <= 1'b1;
    end else begin
      r_cts_meta <= cts_n_in;
      r_cts_sync <= r_cts_meta;
    end
  end

  assign w_cts_ok = !r_cts_sync;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (clk_in),
    .i_rst_n     (rst_in_n),
    .i_wr_en     (valid_in),
    .i_wr_data   (data_in),
    .i_rd_en     (w_pop),
    .o_rd_data_c (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  assign w_start_ok = !w_empty && w_cts_ok;
  assign w_baud_inc = r_baud + BW'(1);
  assign w_bit_end  = (r_baud == BW'(BAUD_COUNT - 1));

  // Next-state logic; the line level is derived from the current state and
  // registered, so tx_out follows the FSM by one cycle throughout the frame.
  always_comb begin : fsm_next
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_pop        = 1'b0;
    w_tx_next    = UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
    w_parity_next = r_parity;
`endif
    case (r_state)
      IDLE: begin
        w_baud_next = '0;
        w_bit_next  = '0;
        if (w_start_ok) begin
          w_state_next = START;
          w_pop        = 1'b1;
        end
      end
      START: begin
        w_tx_next   = 1'b0;
        w_baud_next = w_baud_inc;
        if (w_bit_end) begin
          w_state_next = DATA;
          w_baud_next  = '0;
          w_bit_next   = '0;
        end
      end
      DATA: begin
        w_tx_next   = r_shift[0];
        w_baud_next = w_baud_inc;
        if (w_bit_end) begin
          w_baud_next  = '0;
          w_shift_next = {1'b0, r_shift[UART_DATA_BITS-1:1]};
          if (r_bit == BIT_LAST) begin
            w_bit_next = '0;
`ifdef UART_TX_PARITY_EN
            w_state_next = PARITY;
`else
            w_state_next = STOP;
`endif
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        w_tx_next   = r_parity;
        w_baud_next = w_baud_inc;
        if (w_bit_end) begin
          w_state_next = STOP;
          w_baud_next  = '0;
        end
      end
`endif
      STOP: begin
        w_tx_next   = UART_IDLE_LEVEL;
        w_baud_next = w_baud_inc;
        // r_bit counts stop bits here; back-to-back frames skip IDLE entirely.
        if (w_bit_end) begin
          w_baud_next = '0;
          if (r_bit == STOP_LAST) begin
            w_bit_next = '0;
            if (w_start_ok) begin
              w_state_next = START;
              w_pop        = 1'b1;
            end else begin
              w_state_next = IDLE;
            end
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // Frame start: move the FIFO head into the shift register.
    if (w_pop) begin
      w_shift_next = w_head;
`ifdef UART_TX_PARITY_EN
      w_parity_next = even_parity(w_head);
`endif
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= UART_IDLE_LEVEL;
      r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
      r_busy  <= (r_state != IDLE) || (w_count != '0);
`ifdef UART_TX_PARITY_EN
      r_parity <= w_parity_next;
`endif
    end
  end

  assign ready_out = !w_full;
  assign count_out = w_count;
  assign tx_out    = r_tx;
  assign busy_out  = r_busy;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized bench for uart_tx_fifo.
// A line decoder turns tx_out back into bytes and compares them against the
// queue of bytes the bench handed over; directed sections check timing.
module tb_uart_tx_fifo;

  localparam int B  = 4;
  localparam int D  = 4;
  localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NB    = 9 + PB;          // index of first stop bit in a frame
  localparam int FRAME = (NB + SB) * B;   // cycles per frame
  localparam int CW    = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    data;
  logic          valid;
  logic          ready;
  logic          cts_n;
  logic          tx;
  logic          busy;
  logic [CW-1:0] count;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            rx_cnt   = 0;
  int            last_wait = 0;
  bit            rnd_on   = 1'b0;
  logic [7:0]    exp_q[$];
  int            st_q[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .BAUD_COUNT (B),
    .FIFO_DEPTH (D),
    .STOP_BITS  (SB)
  ) dut (
    .clk_in    (clk),
    .rst_in_n  (rst_n),
    .data_in   (data),
    .valid_in  (valid),
    .ready_out (ready),
    .cts_n_in  (cts_n),
    .tx_out    (tx),
    .busy_out  (busy),
    .count_out (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Level of bit j of a frame carrying byte b.
  function automatic logic frame_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (PB == 1 && j == 9) return ^b;
    return 1'b1;
  endfunction

  // Line decoder: samples each bit in its middle, compares with sent bytes.
  initial begin : mon
    bit         active;
    int         c;
    int         k;
    logic [7:0] rb;
    active = 1'b0; c = 0; rb = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        active = 1'b0;
        continue;
      end
      if (!active && tx === 1'b0) begin
        active = 1'b1;
        c = 0;
        rb = '0;
        st_q.push_back(cyc);
      end
      if (active) begin
        if (c % B == B / 2) begin
          k = c / B;
          if (k == 0) check("mon_start", tx, 0);
          else if (k <= 8) rb[k-1] = tx;
          else if (k < NB) check("mon_parity", tx, ^rb);
          else begin
            check("mon_stop", tx, 1);
            active = 1'b0;
            rx_cnt++;
            if (exp_q.size() == 0) check("mon_unexpected_frame", 1, 0);
            else check("mon_byte", rb, exp_q.pop_front());
          end
        end
        c++;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [7:0] b, input bit keep);
    int w;
    w = 0;
    valid = 1'b1;
    data  = b;
    while (!ready && w < 3000) begin
      @(negedge clk);
      w++;
    end
    last_wait = w;
    if (!ready) begin
      check("push_timeout", 0, 1);
      valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(b);
      @(negedge clk);
      if (!keep) valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int w;
    w = 0;
    repeat (2) @(negedge clk);
    while (busy !== 1'b0 && w < budget) begin
      @(negedge clk);
      w++;
    end
    check("idle_reached", busy, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int  base;
    int  w;
    int  r0;
    bit  ok;

    rst_n = 1'b0; valid = 1'b0; data = '0; cts_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single byte: exact line waveform, start latency and busy fall.
    push(8'hA5, 1'b0);
    for (int k = 1; k <= FRAME + 4; k++) begin
      check("t1_line", tx, (k < 3 || k > 2 + FRAME) ? 1'b1 : frame_bit(8'hA5, (k - 3) / B));
      if (k == 2 + FRAME) check("t1_busy_last", busy, 1);
      if (k == 3 + FRAME) check("t1_busy_drop", busy, 0);
      if (k < FRAME + 4) @(negedge clk);
    end
    check("t1_frames", rx_cnt, 1);

    // Back-to-back bytes with valid held; sixth refused until a slot frees.
    base = st_q.size();
    for (int i = 1; i <= 5; i++) push(8'(i), 1'b1);
    check("t2_ready_low", ready, 0);
    check("t2_count_full", count, D);
    push(8'h06, 1'b0);
    check("t2_refused", last_wait > 0, 1);
    wait_idle(2000);
    check("t2_frames", st_q.size() - base, 6);
    for (int i = 1; i < 6; i++)
      if (base + i < st_q.size())
        check("t2_gap", st_q[base+i] - st_q[base+i-1], FRAME);

    // CTS held off: byte waits; release starts the frame within 4 cycles.
    cts_n = 1'b1;
    repeat (3) @(negedge clk);
    push(8'h3C, 1'b0);
    ok = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) ok = 1'b0;
    end
    check("t3_line_held", ok, 1);
    check("t3_count", count, 1);
    check("t3_busy", busy, 1);
    cts_n = 1'b0;
    w = 0;
    while (tx !== 1'b0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("t3_start", tx, 0);
    check("t3_latency_le4", w <= 4, 1);
    wait_idle(200);

    // CTS dropped mid-frame: frame completes, next byte stays queued.
    r0 = rx_cnt;
    push(8'hFF, 1'b0);
    push(8'h11, 1'b0);
    w = 0;
    while (tx !== 1'b0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    repeat (B + 3 * B) @(negedge clk);
    cts_n = 1'b1;
    repeat (FRAME) @(negedge clk);
    ok = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (tx !== 1'b1) ok = 1'b0;
    end
    check("t4_line_idle", ok, 1);
    check("t4_count", count, 1);
    check("t4_one_frame", rx_cnt - r0, 1);
    cts_n = 1'b0;
    wait_idle(200);

    // Reset during data bit 3 with two bytes queued.
    r0 = rx_cnt;
    push(8'h5A, 1'b0);
    push(8'hC3, 1'b0);
    push(8'h96, 1'b0);
    w = 0;
    while (tx !== 1'b0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    repeat (B + 3 * B + 1) @(negedge clk);
    check("t5_in_frame", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_tx", tx, 1);
    check("t5_count", count, 0);
    check("t5_ready", ready, 1);
    check("t5_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) ok = 1'b0;
    end
    check("t5_line_quiet", ok, 1);
    check("t5_no_frames", rx_cnt - r0, 0);

    // Random bytes, random gaps, CTS toggling in the background.
    rnd_on = 1'b1;
    fork
      begin
        while (rnd_on) begin
          repeat ($urandom_range(20, 80)) @(negedge clk);
          if (rnd_on) cts_n = ($urandom_range(0, 3) == 0);
        end
      end
    join_none
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push(8'($urandom), 1'b0);
    end
    rnd_on = 1'b0;
    cts_n  = 1'b0;
    wait_idle(3000);
    check("end_all_sent", exp_q.size(), 0);
    check("end_count", count, 0);
    check("end_ready", ready, 1);
    check("end_tx", tx, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
